// File: rtl/lsu_bus_bridge_pkg.sv
// Shared encodings for the LSU bus bridge: data width, RISC-V load/store funct3,
// FSM state codes and the alignment rule used by the bridge.
package lsu_bus_bridge_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_WAIT_R = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Sizes 11 and the 11x encodings are illegal and reported as misaligned.
  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] offset);
    if (f3[2:1] == 2'b11) return 1'b0;
    case (f3[1:0])
      2'b00:   return 1'b1;
      2'b01:   return ~offset[0];
      2'b10:   return offset == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: store strobe/data replication and load lane
// select with sign/zero extension. Shared with future cache front-ends.
module lsu_lane_align
  import lsu_bus_bridge_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic            we,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rword,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data
);

  logic [XLEN-1:0] rshift;

  assign rshift = rword >> {offset, 3'b000};

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    wstrb     = 4'b0000;
    wdata     = store_data;
    load_data = '0;

    case (funct3[1:0])
      2'b00: begin
        wstrb = 4'b0001 << offset;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        wstrb = 4'b0011 << offset;
        wdata = {2{store_data[15:0]}};
      end
      default: wstrb = 4'b1111;
    endcase
    if (!we) wstrb = 4'b0000;

    case (funct3)
      F3_LB:   load_data = {{24{rshift[7]}}, rshift[7:0]};
      F3_LH:   load_data = {{16{rshift[15]}}, rshift[15:0]};
      F3_LW:   load_data = rshift;
      F3_LBU:  load_data = {24'd0, rshift[7:0]};
      F3_LHU:  load_data = {16'd0, rshift[15:0]};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Converts the mem-stage load/store request into a valid/ready bus transaction,
// stalling the pipeline while it is outstanding and flagging misalign/timeout.
module lsu_bus_bridge
  import lsu_bus_bridge_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] mem_addr_i,
  input  logic [XLEN-1:0] mem_wdata_i,
  input  logic            mem_re_i,
  input  logic            mem_we_i,
  input  logic [2:0]      opfunc3_i,
  output logic [XLEN-1:0] rdata_o,
  output logic            stall_o,
  output logic            err_o,
  output logic            bus_valid_o,
  input  logic            bus_ready_i,
  output logic [XLEN-1:0] bus_addr_o,
  output logic            bus_we_o,
  output logic [3:0]      bus_wstrb_o,
  output logic [XLEN-1:0] bus_wdata_o,
  input  logic            bus_rvalid_i,
  input  logic [XLEN-1:0] bus_rdata_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [1:0]       state_q, state_d;
  logic [XLEN-1:0]  addr_q, wdata_q, rdata_q;
  logic             we_q, err_q;
  logic [2:0]       f3_q;
  logic [CNT_W-1:0] cnt_q;

  logic req, aligned, start, misalign, in_flight, completing, abort;
  logic [3:0]      lane_strb;
  logic [XLEN-1:0] lane_wdata, load_ext;

  assign req        = mem_re_i | mem_we_i;
  assign aligned    = is_aligned(opfunc3_i, mem_addr_i[1:0]);
  assign start      = (state_q == ST_IDLE) && req && aligned;
  assign misalign   = (state_q == ST_IDLE) && req && !aligned;
  assign in_flight  = (state_q == ST_REQ) || (state_q == ST_WAIT_R);
  assign completing = ((state_q == ST_REQ) && bus_ready_i) ||
                      ((state_q == ST_WAIT_R) && bus_rvalid_i);
  // A handshake landing on the last allowed cycle wins over the timeout.
  assign abort      = (TIMEOUT_CYCLES != 0) && in_flight && (cnt_q == CNT_LAST) && !completing;

  lsu_lane_align u_lane_align (
    .funct3     (f3_q),
    .offset     (addr_q[1:0]),
    .we         (we_q),
    .store_data (wdata_q),
    .rword      (bus_rdata_i),
    .wstrb      (lane_strb),
    .wdata      (lane_wdata),
    .load_data  (load_ext)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_REQ;
      ST_REQ: begin
        if (bus_ready_i) state_d = we_q ? ST_DONE : ST_WAIT_R;
        else if (abort)  state_d = ST_DONE;
      end
      ST_WAIT_R: if (bus_rvalid_i || abort) state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values.
      state_q <= state_d;
      err_q   <= 1'b0;
      if (start) begin
        addr_q  <= mem_addr_i;
        wdata_q <= mem_wdata_i;
        we_q    <= mem_we_i;
        f3_q    <= opfunc3_i;
      end
      cnt_q <= (in_flight && ((state_d == ST_REQ) || (state_d == ST_WAIT_R))) ? cnt_q + 1'b1 : '0;
      if ((state_q == ST_WAIT_R) && bus_rvalid_i) begin
        rdata_q <= load_ext;
      end else if (misalign || abort) begin
        // Errors return zero data alongside the err pulse.
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign bus_valid_o = (state_q == ST_REQ);
  assign bus_addr_o  = bus_valid_o ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign bus_we_o    = bus_valid_o & we_q;
  assign bus_wstrb_o = bus_valid_o ? lane_strb : 4'b0000;
  assign bus_wdata_o = (bus_valid_o && we_q) ? lane_wdata : '0;
  assign stall_o     = start | in_flight;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed self-checking bench for lsu_bus_bridge: stores, loads, misalign,
// timeout (second instance with a short limit) and reset mid-transaction.
module tb_lsu_bus_bridge;
  import lsu_bus_bridge_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] mem_addr_i = '0, mem_wdata_i = '0;
  logic        mem_re_i = 1'b0, mem_we_i = 1'b0;
  logic [2:0]  opfunc3_i = 3'b000;
  logic        bus_ready_i = 1'b0, bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = 32'hBAD0BAD0;

  logic [31:0] rdata_o, bus_addr_o, bus_wdata_o;
  logic        stall_o, err_o, bus_valid_o, bus_we_o;
  logic [3:0]  bus_wstrb_o;

  logic [31:0] to_rdata, to_addr, to_wdata;
  logic        to_stall, to_err, to_valid, to_we;
  logic [3:0]  to_wstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  lsu_bus_bridge #(.XLEN(32), .TIMEOUT_CYCLES(255)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .opfunc3_i(opfunc3_i), .rdata_o(rdata_o),
    .stall_o(stall_o), .err_o(err_o), .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i),
    .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o), .bus_wstrb_o(bus_wstrb_o),
    .bus_wdata_o(bus_wdata_o), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  lsu_bus_bridge #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut_to (
    .clk_i(clk_i), .rst_i(rst_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .opfunc3_i(opfunc3_i), .rdata_o(to_rdata),
    .stall_o(to_stall), .err_o(to_err), .bus_valid_o(to_valid), .bus_ready_i(bus_ready_i),
    .bus_addr_o(to_addr), .bus_we_o(to_we), .bus_wstrb_o(to_wstrb),
    .bus_wdata_o(to_wdata), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    mem_addr_i = a; mem_wdata_i = d; opfunc3_i = f3;
    mem_we_i = 1'b1; mem_re_i = 1'b0; bus_ready_i = 1'b1;
    #1 check("st_idle_stall", {31'd0, stall_o}, 32'd1);
    cyc();
    check("st_valid", {31'd0, bus_valid_o}, 32'd1);
    check("st_addr", bus_addr_o, {a[31:2], 2'b00});
    check("st_we", {31'd0, bus_we_o}, 32'd1);
    check("st_wstrb", {28'd0, bus_wstrb_o}, {28'd0, exp_strb});
    check("st_wdata", bus_wdata_o, exp_wdata);
    check("st_req_stall", {31'd0, stall_o}, 32'd1);
    cyc();
    check("st_done_stall", {31'd0, stall_o}, 32'd0);
    check("st_done_valid", {31'd0, bus_valid_o}, 32'd0);
    mem_we_i = 1'b0;
    cyc();
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] word,
                         input int delay, input logic [31:0] exp);
    mem_addr_i = a; opfunc3_i = f3;
    mem_re_i = 1'b1; mem_we_i = 1'b0; bus_ready_i = 1'b1;
    #1 check("ld_idle_stall", {31'd0, stall_o}, 32'd1);
    cyc();
    check("ld_valid", {31'd0, bus_valid_o}, 32'd1);
    check("ld_addr", bus_addr_o, {a[31:2], 2'b00});
    check("ld_wstrb", {28'd0, bus_wstrb_o}, 32'd0);
    check("ld_we", {31'd0, bus_we_o}, 32'd0);
    for (int i = 1; i <= delay; i++) begin
      cyc();
      check("ld_wait_stall", {31'd0, stall_o}, 32'd1);
      check("ld_wait_valid", {31'd0, bus_valid_o}, 32'd0);
      if (i == delay) begin
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = word;
      end
    end
    cyc();
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = 32'hBAD0BAD0;
    check("ld_rdata", rdata_o, exp);
    check("ld_done_stall", {31'd0, stall_o}, 32'd0);
    check("ld_done_err", {31'd0, err_o}, 32'd0);
    mem_re_i = 1'b0;
    cyc();
    check("ld_rdata_hold", rdata_o, exp);
  endtask

  task automatic do_misalign(input logic [31:0] a, input logic [2:0] f3);
    mem_addr_i = a; opfunc3_i = f3; mem_re_i = 1'b1; mem_we_i = 1'b0;
    #1 check("mis_stall", {31'd0, stall_o}, 32'd0);
    check("mis_valid", {31'd0, bus_valid_o}, 32'd0);
    cyc();
    mem_re_i = 1'b0;
    #1 check("mis_err", {31'd0, err_o}, 32'd1);
    check("mis_rdata", rdata_o, 32'd0);
    check("mis_valid2", {31'd0, bus_valid_o}, 32'd0);
    cyc();
    check("mis_err_pulse", {31'd0, err_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_valid", {31'd0, bus_valid_o}, 32'd0);
    check("rst_wstrb", {28'd0, bus_wstrb_o}, 32'd0);
    cyc();
    rst_i = 1'b1;
    cyc();

    do_store(32'h100, 32'hDEADBEEF, F3_SW, 4'b1111, 32'hDEADBEEF);
    do_store(32'h103, 32'h000000A5, F3_SB, 4'b1000, 32'hA5A5A5A5);
    do_store(32'h102, 32'h1234BEEF, F3_SH, 4'b1100, 32'hBEEFBEEF);

    do_load(32'h102, F3_LB,  32'h0080FF00, 3, 32'hFFFFFF80);
    do_load(32'h102, F3_LHU, 32'h0080FF00, 1, 32'h00000080);
    do_load(32'h100, F3_LH,  32'h0080FF00, 2, 32'hFFFFFF00);

    do_misalign(32'h101, F3_LW);
    do_misalign(32'h100, 3'b011);
    do_misalign(32'h100, 3'b110);

    do_load(32'h104, F3_LW, 32'h12345678, 1, 32'h12345678);

    // Timeout on the short-limit instance; the main instance just stays in REQ.
    mem_addr_i = 32'h200; opfunc3_i = F3_LW; mem_re_i = 1'b1; bus_ready_i = 1'b0;
    #1 check("to_idle_stall", {31'd0, to_stall}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("to_req_valid", {31'd0, to_valid}, 32'd1);
      check("to_req_err", {31'd0, to_err}, 32'd0);
    end
    cyc();
    check("to_err", {31'd0, to_err}, 32'd1);
    check("to_valid_drop", {31'd0, to_valid}, 32'd0);
    check("to_rdata", to_rdata, 32'd0);
    check("to_stall", {31'd0, to_stall}, 32'd0);
    mem_re_i = 1'b0;
    cyc();
    check("to_err_pulse", {31'd0, to_err}, 32'd0);

    rst_i = 1'b0;
    #1 check("rst2_rdata", rdata_o, 32'd0);
    check("rst2_valid", {31'd0, bus_valid_o}, 32'd0);
    check("rst2_stall", {31'd0, stall_o}, 32'd0);
    cyc();
    rst_i = 1'b1;
    cyc();

    // Reset while waiting for read data; the late rvalid must be ignored.
    mem_addr_i = 32'h300; opfunc3_i = F3_LW; mem_re_i = 1'b1; bus_ready_i = 1'b1;
    cyc();
    cyc();
    check("wr_wait_stall", {31'd0, stall_o}, 32'd1);
    #2;
    rst_i = 1'b0;
    mem_re_i = 1'b0;
    #1 check("wr_rst_stall", {31'd0, stall_o}, 32'd0);
    check("wr_rst_valid", {31'd0, bus_valid_o}, 32'd0);
    check("wr_rst_err", {31'd0, err_o}, 32'd0);
    cyc();
    rst_i = 1'b1;
    cyc();
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hCAFEF00D;
    cyc();
    bus_rvalid_i = 1'b0;
    check("wr_late_rdata", rdata_o, 32'd0);
    check("wr_late_stall", {31'd0, stall_o}, 32'd0);
    check("wr_late_valid", {31'd0, bus_valid_o}, 32'd0);
    cyc();
    check("wr_idle_rdata", rdata_o, 32'd0);
    check("wr_idle_valid", {31'd0, bus_valid_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
